// File: rtl/seq_chk_if.sv
// Bus between the seq_chk checker and whatever drives the signal under check.
interface seq_chk_if #(
    parameter int unsigned IW = 1
) ();
    logic          en;
    logic          sig;
    logic [IW-1:0] idx;
    logic          active;
    logic          done;
    logic          pass;
    logic          fail;
    logic [IW-1:0] err_idx;
    logic          rose;
    logic          fell;
    logic          changed;

    // Stimulus side: drives the start pulse and the checked signal.
    modport master (
        output en,
        output sig,
        input  idx,
        input  active,
        input  done,
        input  pass,
        input  fail,
        input  err_idx,
        input  rose,
        input  fell,
        input  changed
    );

    // Checker side.
    modport slave (
        input  en,
        input  sig,
        output idx,
        output active,
        output done,
        output pass,
        output fail,
        output err_idx,
        output rose,
        output fell,
        output changed
    );
endinterface

// File: rtl/seq_chk.sv
// Waveform checker: after a start pulse, compares sig cycle by cycle against a
// character pattern ('_' = 0, '-' = 1, anything else = don't care) and reports
// pass/fail with the index of the first mismatch, plus edge flags on sig.
module seq_chk #(
    parameter int unsigned    N       = 20,
    parameter logic [8*N-1:0] PATTERN = "____________________",
    parameter int unsigned    LOOP    = 0
) (
    input  logic      clk,
    input  logic      rst,
    seq_chk_if.slave  bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_e;

    // Pattern decode at elaboration: one bit per character, leftmost is bit 0.
    // want_one=1 gives the expected level, want_one=0 gives the care mask.
    function automatic logic [N-1:0] decode(input bit want_one);
        logic [N-1:0] m;
        logic [7:0]   c;
        m = '0;
        for (int i = 0; i < int'(N); i++) begin
            c = PATTERN[8*(int'(N)-1-i) +: 8];
            if (want_one) begin
                m[i] = (c == "-");
            end else begin
                m[i] = (c == "-") || (c == "_");
            end
        end
        return m;
    endfunction

    localparam logic [N-1:0] CARE = decode(1'b0);
    localparam logic [N-1:0] VAL  = decode(1'b1);

    state_e        state_q,      state_d;
    logic [IW-1:0] idx_q,        idx_d;
    logic [IW-1:0] err_idx_q,    err_idx_d;
    logic          active_q,     active_d;
    logic          done_q,       done_d;
    logic          pass_q,       pass_d;
    logic          fail_q,       fail_d;
    logic          prev_q,       prev_d;
    logic          prev_valid_q, prev_valid_d;

    logic [N-1:0]  sel_c;
    logic          care_c;
    logic          want_c;
    logic          hit_c;
    logic          last_c;

    // Select the character at the current index and test sig against it.
    always_comb begin
        sel_c  = N'(1) << idx_q;
        care_c = |(CARE & sel_c);
        want_c = |(VAL & sel_c);
        hit_c  = ~care_c | (bus.sig == want_c);
        last_c = (idx_q == IW'(N - 1));
    end

    // Next-state and next-output logic for the checker FSM.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_idx_d    = err_idx_q;
        active_d     = active_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;

        case (state_q)
            S_IDLE: begin
                idx_d        = '0;
                prev_valid_d = 1'b0;
                if (bus.en) begin
                    state_d  = S_RUN;
                    active_d = 1'b1;
                end
            end
            S_RUN: begin
                prev_d       = bus.sig;
                prev_valid_d = 1'b1;
                if (!hit_c) begin
                    // idx holds at the failing character
                    state_d   = S_FAIL;
                    active_d  = 1'b0;
                    fail_d    = 1'b1;
                    err_idx_d = idx_q;
                end else if (last_c) begin
                    if (LOOP != 0) begin
                        idx_d = '0;
                    end else begin
                        state_d  = S_DONE;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        pass_d   = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
            end
            S_FAIL: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            err_idx_q    <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            err_idx_q    <= err_idx_d;
            active_q     <= active_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    // Registered status onto the bus.
    assign bus.idx     = idx_q;
    assign bus.err_idx = err_idx_q;
    assign bus.active  = active_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.fail    = fail_q;

    // Edge flags follow the live sig against the last RUN sample.
    assign bus.rose    = active_q & prev_valid_q & bus.sig & ~prev_q;
    assign bus.fell    = active_q & prev_valid_q & ~bus.sig & prev_q;
    assign bus.changed = bus.rose | bus.fell;
endmodule

// File: tb/tb_seq_chk.sv
// Bench for seq_chk: four checker configurations share clk/rst/en/sig; a
// sample-history reference model predicts every output of every instance.
module tb_seq_chk;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sig;

    always #5 clk = ~clk;

    seq_chk_if #(.IW(2)) if0 ();
    seq_chk_if #(.IW(2)) if1 ();
    seq_chk_if #(.IW(1)) if2 ();
    seq_chk_if #(.IW(1)) if3 ();

    assign if0.en = en;  assign if0.sig = sig;
    assign if1.en = en;  assign if1.sig = sig;
    assign if2.en = en;  assign if2.sig = sig;
    assign if3.en = en;  assign if3.sig = sig;

    seq_chk #(.N(4), .PATTERN("_-_-"), .LOOP(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_chk #(.N(4), .PATTERN("_..-"), .LOOP(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    seq_chk #(.N(2), .PATTERN("-_"),   .LOOP(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    seq_chk #(.N(1), .PATTERN("-"),    .LOOP(0)) u3 (.clk(clk), .rst(rst), .bus(if3));

    // Flags packed as {active, done, pass, fail, rose, fell, changed}.
    logic [7:0] g_idx [ND];
    logic [7:0] g_err [ND];
    logic [6:0] g_fl  [ND];

    assign g_idx[0] = 8'(if0.idx);  assign g_err[0] = 8'(if0.err_idx);
    assign g_idx[1] = 8'(if1.idx);  assign g_err[1] = 8'(if1.err_idx);
    assign g_idx[2] = 8'(if2.idx);  assign g_err[2] = 8'(if2.err_idx);
    assign g_idx[3] = 8'(if3.idx);  assign g_err[3] = 8'(if3.err_idx);
    assign g_fl[0] = {if0.active, if0.done, if0.pass, if0.fail, if0.rose, if0.fell, if0.changed};
    assign g_fl[1] = {if1.active, if1.done, if1.pass, if1.fail, if1.rose, if1.fell, if1.changed};
    assign g_fl[2] = {if2.active, if2.done, if2.pass, if2.fail, if2.rose, if2.fell, if2.changed};
    assign g_fl[3] = {if3.active, if3.done, if3.pass, if3.fail, if3.rose, if3.fell, if3.changed};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a run is the list of samples taken since the start
    // pulse; only its length, last value and first mismatch matter.
    string pat [ND] = '{"_-_-", "_..-", "-_", "-"};
    int    nn  [ND] = '{4, 4, 2, 1};
    bit    lp  [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};

    bit m_valid = 1'b0;
    bit m_started [ND];
    bit m_failed  [ND];
    int m_len     [ND];
    int m_err     [ND];
    bit m_last    [ND];

    function automatic int exp_val(input int d, input int k);
        byte c;
        c = pat[d].getc(k);
        if (c == "_") return 0;
        if (c == "-") return 1;
        return -1;
    endfunction

    function automatic bit m_running(input int d);
        return m_started[d] && !m_failed[d] && !(!lp[d] && m_len[d] == nn[d]);
    endfunction

    task automatic model_step();
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_started[d] = 1'b0;
                m_failed[d]  = 1'b0;
                m_len[d]     = 0;
                m_err[d]     = 0;
            end else if (!m_started[d]) begin
                if (en) m_started[d] = 1'b1;
            end else if (m_running(d)) begin
                int k;
                int e;
                k = m_len[d] % nn[d];
                e = exp_val(d, k);
                if (e >= 0 && e != int'(sig)) begin
                    m_failed[d] = 1'b1;
                    m_err[d]    = k;
                end else begin
                    m_len[d] = m_len[d] + 1;
                end
                m_last[d] = sig;
            end
        end
        if (rst) m_valid = 1'b1;
    endtask

    task automatic check_model(input string tag);
        if (m_valid) begin
            for (int d = 0; d < ND; d++) begin
                bit run;
                bit dn;
                bit ro;
                bit fe;
                int e_idx;
                logic [7:0] e_i;
                logic [7:0] g_i;
                logic [6:0] e_fl;
                run   = m_running(d);
                dn    = m_started[d] && !m_failed[d] && !run;
                ro    = run && m_len[d] > 0 && sig && !m_last[d];
                fe    = run && m_len[d] > 0 && !sig && m_last[d];
                e_idx = run ? (m_len[d] % nn[d]) : (m_failed[d] ? m_err[d] : 0);
                e_fl  = {run, dn, dn, m_failed[d], ro, fe, ro | fe};
                // index after a completed run is left unconstrained
                e_i   = dn ? 8'd0 : 8'(e_idx);
                g_i   = dn ? 8'd0 : g_idx[d];
                vectors++;
                if (g_i != e_i || g_err[d] != 8'(m_failed[d] ? m_err[d] : 0) || g_fl[d] != e_fl) begin
                    miscompares++;
                    $display("FAIL %s dut%0d: got idx=%0d err_idx=%0d flags=%b, want idx=%0d err_idx=%0d flags=%b",
                             tag, d, g_i, g_err[d], g_fl[d], e_i,
                             m_failed[d] ? m_err[d] : 0, e_fl);
                end
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Drive inputs mid-low-phase and check everything before the next edge.
    task automatic apply(input bit r, input bit e, input bit s, input string tag);
        rst = r;
        en  = e;
        sig = s;
        #1;
        check_model(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(input bit r, input bit e, input bit s, input string tag);
        apply(r, e, s, tag);
        advance();
    endtask

    typedef struct packed {
        logic       rst, en, sig, chk;
        logic [1:0] idx;
        logic       act, done, pass, fail;
        logic [1:0] err;
        logic       rose, fell, chg;
    } vec_t;

    function automatic vec_t mk(input int r, e, s, c, i, a, dn, p, f, er, ro, fe, ch);
        vec_t v;
        v.rst = 1'(r);  v.en = 1'(e);  v.sig = 1'(s);  v.chk = 1'(c);
        v.idx = 2'(i);  v.act = 1'(a); v.done = 1'(dn); v.pass = 1'(p);
        v.fail = 1'(f); v.err = 2'(er); v.rose = 1'(ro); v.fell = 1'(fe);
        v.chg = 1'(ch);
        return v;
    endfunction

    vec_t tbl [25];

    initial begin
        // rst en sig chk | idx act done pass fail err rose fell chg   (dut0, "_-_-")
        tbl[0]  = mk(1,0,0,0, 0,0,0,0,0,0, 0,0,0);
        tbl[1]  = mk(0,1,0,1, 0,0,0,0,0,0, 0,0,0);
        tbl[2]  = mk(0,0,0,1, 0,1,0,0,0,0, 0,0,0);
        tbl[3]  = mk(0,0,1,1, 1,1,0,0,0,0, 1,0,1);
        tbl[4]  = mk(0,0,0,1, 2,1,0,0,0,0, 0,1,1);
        tbl[5]  = mk(0,0,1,1, 3,1,0,0,0,0, 1,0,1);
        tbl[6]  = mk(0,0,0,1, 0,0,1,1,0,0, 0,0,0);
        tbl[7]  = mk(0,1,1,1, 0,0,1,1,0,0, 0,0,0);
        tbl[8]  = mk(1,0,0,1, 0,0,1,1,0,0, 0,0,0);
        tbl[9]  = mk(0,1,0,1, 0,0,0,0,0,0, 0,0,0);
        tbl[10] = mk(0,0,0,1, 0,1,0,0,0,0, 0,0,0);
        tbl[11] = mk(0,0,1,1, 1,1,0,0,0,0, 1,0,1);
        tbl[12] = mk(0,0,1,1, 2,1,0,0,0,0, 0,0,0);
        tbl[13] = mk(0,1,0,1, 2,0,0,0,1,2, 0,0,0);
        tbl[14] = mk(0,1,1,1, 2,0,0,0,1,2, 0,0,0);
        tbl[15] = mk(1,0,0,1, 2,0,0,0,1,2, 0,0,0);
        tbl[16] = mk(0,1,0,1, 0,0,0,0,0,0, 0,0,0);
        tbl[17] = mk(0,0,0,1, 0,1,0,0,0,0, 0,0,0);
        tbl[18] = mk(0,0,1,1, 1,1,0,0,0,0, 1,0,1);
        tbl[19] = mk(1,0,0,1, 2,1,0,0,0,0, 0,1,1);
        tbl[20] = mk(1,1,0,1, 0,0,0,0,0,0, 0,0,0);
        tbl[21] = mk(0,0,1,1, 0,0,0,0,0,0, 0,0,0);
        tbl[22] = mk(0,1,0,1, 0,0,0,0,0,0, 0,0,0);
        tbl[23] = mk(0,0,1,1, 0,1,0,0,0,0, 0,0,0);
        tbl[24] = mk(0,0,0,1, 0,0,0,0,1,0, 0,0,0);

        rst = 1'b1;
        en  = 1'b0;
        sig = 1'b0;
        @(negedge clk);

        // Table: pass, fail at idx 2, terminal states, reset during RUN.
        for (int i = 0; i < 25; i++) begin
            vec_t t;
            logic [10:0] got;
            logic [10:0] want;
            t = tbl[i];
            apply(t.rst, t.en, t.sig, "table_model");
            if (t.chk) begin
                want = {t.done ? 2'd0 : t.idx, t.err, t.act, t.done, t.pass, t.fail,
                        t.rose, t.fell, t.chg};
                got  = {t.done ? 2'd0 : g_idx[0][1:0], g_err[0][1:0], g_fl[0]};
                vectors++;
                if (got != want) begin
                    miscompares++;
                    $display("FAIL table row %0d: got %b, want %b", i, got, want);
                end
            end
            advance();
        end

        // dut1 "_..-": don't-care positions pass, then a miss on the last char.
        step(1, 0, 0, "dc_rst");
        step(0, 1, 0, "dc_en");
        step(0, 0, 0, "dc_s0");
        step(0, 0, 1, "dc_s1");
        step(0, 0, 0, "dc_s2");
        step(0, 0, 1, "dc_s3");
        apply(0, 0, 0, "dc_end");
        chk("dc_pass", int'(g_fl[1][4]), 1);
        chk("dc_done", int'(g_fl[1][5]), 1);
        advance();
        step(1, 0, 0, "dc2_rst");
        step(0, 1, 0, "dc2_en");
        step(0, 0, 0, "dc2_s0");
        step(0, 0, 1, "dc2_s1");
        step(0, 0, 1, "dc2_s2");
        step(0, 0, 0, "dc2_s3");
        apply(0, 0, 0, "dc2_end");
        chk("dc2_fail", int'(g_fl[1][3]), 1);
        chk("dc2_err_idx", int'(g_err[1]), 3);
        chk("dc2_done", int'(g_fl[1][5]), 0);
        advance();

        // dut2 "-_" looping: idx wraps, active stays high, changed after first.
        step(1, 0, 0, "loop_rst");
        step(0, 1, 1, "loop_en");
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, (i % 2 == 0) ? 1'b1 : 1'b0, "loop_run");
            chk("loop_idx", int'(g_idx[2]), i % 2);
            chk("loop_active", int'(g_fl[2][6]), 1);
            chk("loop_done_fail", int'(g_fl[2][5] | g_fl[2][3]), 0);
            chk("loop_changed", int'(g_fl[2][0]), (i > 0) ? 1 : 0);
            advance();
        end

        // dut3 N=1: single compare decides pass or fail.
        step(1, 0, 0, "n1_rst");
        step(0, 1, 0, "n1_en");
        step(0, 0, 1, "n1_hit");
        apply(0, 0, 1, "n1_end");
        chk("n1_pass", int'(g_fl[3][4]), 1);
        advance();
        step(1, 0, 0, "n1b_rst");
        step(0, 1, 0, "n1b_en");
        step(0, 0, 0, "n1b_miss");
        apply(0, 0, 0, "n1b_end");
        chk("n1b_fail", int'(g_fl[3][3]), 1);
        chk("n1b_err_idx", int'(g_err[3]), 0);
        advance();

        // Random traffic, biased toward each instance's expected waveform in turn.
        for (int c = 0; c < 3000; c++) begin
            int tgt;
            int e;
            bit s;
            tgt = (c / 250) % ND;
            s   = 1'($urandom_range(0, 1));
            if (m_running(tgt)) begin
                e = exp_val(tgt, m_len[tgt] % nn[tgt]);
                if (e >= 0 && $urandom_range(0, 7) != 0) s = 1'(e);
            end
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, s, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
